// File: rtl/bank_pkg.sv
// Shared bank definitions: opcodes, request field widths and the request payload struct.
// Imported by the bank-side arbiters and the bank top.
package bank_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam int unsigned ADDR_HI   = 31;
    localparam int unsigned ADDR_LO   = 4;
    localparam int unsigned ADDR_W    = ADDR_HI - ADDR_LO + 1;
    localparam int unsigned DATA_W    = 128;
    localparam int unsigned WBUF_ID_W = 8;

    typedef struct packed {
        logic [1:0]           opcode;
        logic [ADDR_W-1:0]    addr;
        logic [DATA_W-1:0]    data;
        logic [WBUF_ID_W-1:0] wbuffer_id;
    } bank_req_t;

endpackage : bank_pkg

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after ptr_i (wrapping).
// Ports:
//   req_i      N   request vector
//   ptr_i      W   index of the last winner; scanning starts at ptr_i+1
//   en_i       1   grant enable; no grant when low
//   gnt_o      N   one-hot grant (zero if no request or disabled)
//   gnt_idx_o  W   encoded index of the granted requester
// N must be a power of two so the W-bit index wraps naturally.
module rr_arbiter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] gnt_idx_o
);

    // Priority scan from ptr_i+1 to ptr_i; the first hit wins.
    always_comb begin
        logic         found;
        logic [W-1:0] cand;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= int'(N); k++) begin
            cand = ptr_i + W'(k);
            if (en_i && !found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                gnt_idx_o    = cand;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/xbar_bank_arbiter.sv
// Shares one bank HTU request port between NUM_CH crossbar channels.
// Round-robin grant into a single registered output stage with valid/allowIn
// handshake; per-channel read credits limit outstanding reads to MAX_RD.
// Ports:
//   clk_i, rst_i (async, active-low)
//   xbar_ch_valid_i/opcode_i/addr_i/data_i/wbuffer_id_i  per-channel request (flattened)
//   xbar_ch_ready_o      one-hot accept, combinational from valid
//   bank_valid_o, bank_allowIn_i, bank_ch_id_o, bank_opcode_o, bank_addr_o,
//   bank_data_o, bank_wbuffer_id_o                        registered output stage
//   bank_rtn_valid_i, bank_rtn_ch_id_i                    read-data return (credit release)
//   credit_full_o        channel has MAX_RD reads outstanding
//   err_o                sticky: return seen with a zero count
// Optional (macro XBAR_BANK_ARB_PERF_EN): perf_grant_cnt_o, perf_stall_cnt_o.
module xbar_bank_arbiter
    import bank_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned MAX_RD = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_CH-1:0]           xbar_ch_valid_i,
    output logic [NUM_CH-1:0]           xbar_ch_ready_o,
    input  logic [2*NUM_CH-1:0]         xbar_ch_opcode_i,
    input  logic [ADDR_W*NUM_CH-1:0]    xbar_ch_addr_i,
    input  logic [DATA_W*NUM_CH-1:0]    xbar_ch_data_i,
    input  logic [WBUF_ID_W*NUM_CH-1:0] xbar_ch_wbuffer_id_i,
    output logic                        bank_valid_o,
    input  logic                        bank_allowIn_i,
    output logic [CH_W-1:0]             bank_ch_id_o,
    output logic [1:0]                  bank_opcode_o,
    output logic [ADDR_W-1:0]           bank_addr_o,
    output logic [DATA_W-1:0]           bank_data_o,
    output logic [WBUF_ID_W-1:0]        bank_wbuffer_id_o,
    input  logic                        bank_rtn_valid_i,
    input  logic [CH_W-1:0]             bank_rtn_ch_id_i,
    output logic [NUM_CH-1:0]           credit_full_o,
    output logic                        err_o
`ifdef XBAR_BANK_ARB_PERF_EN
    ,
    output logic [16*NUM_CH-1:0]        perf_grant_cnt_o,
    output logic [15:0]                 perf_stall_cnt_o
`endif
);

    localparam int unsigned CNT_W = 3;

    logic                         bank_valid_q;
    bank_req_t                    req_q;
    logic [CH_W-1:0]              ch_id_q;
    logic [CH_W-1:0]              ptr_q;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                         err_q, err_d;

    logic [NUM_CH-1:0] elig_c;
    logic [NUM_CH-1:0] gnt_c;
    logic [CH_W-1:0]   gnt_idx_c;
    logic              any_gnt_c;
    logic              load_c;
    bank_req_t         sel_req_c;

    // Stage can take a new request when empty or draining this cycle.
    assign load_c = !bank_valid_q || bank_allowIn_i;

    // Eligibility uses the registered count, so a same-cycle return does not unblock.
    always_comb begin
        elig_c = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            elig_c[i] = xbar_ch_valid_i[i] &&
                        ((xbar_ch_opcode_i[2*i +: 2] != OP_READ) ||
                         (cnt_q[i] < CNT_W'(MAX_RD)));
        end
    end

    rr_arbiter #(
        .N (NUM_CH),
        .W (CH_W)
    ) u_rr (
        .req_i     (elig_c),
        .ptr_i     (ptr_q),
        .en_i      (load_c),
        .gnt_o     (gnt_c),
        .gnt_idx_o (gnt_idx_c)
    );

    assign any_gnt_c       = |gnt_c;
    assign xbar_ch_ready_o = gnt_c;

    // One-hot payload mux.
    always_comb begin
        sel_req_c = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (gnt_c[i]) begin
                sel_req_c.opcode     = xbar_ch_opcode_i[2*i +: 2];
                sel_req_c.addr       = xbar_ch_addr_i[ADDR_W*i +: ADDR_W];
                sel_req_c.data       = xbar_ch_data_i[DATA_W*i +: DATA_W];
                sel_req_c.wbuffer_id = xbar_ch_wbuffer_id_i[WBUF_ID_W*i +: WBUF_ID_W];
            end
        end
    end

    // Output stage and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bank_valid_q <= 1'b0;
            req_q        <= '0;
            ch_id_q      <= '0;
            ptr_q        <= CH_W'(NUM_CH - 1);
        end else if (load_c) begin
            bank_valid_q <= any_gnt_c;
            if (any_gnt_c) begin
                req_q   <= sel_req_c;
                ch_id_q <= gnt_idx_c;
                ptr_q   <= gnt_idx_c;
            end
        end
    end

    // Credit update: grant of a READ adds, return subtracts, both cancel.
    always_comb begin
        logic inc;
        logic dec;
        cnt_d = cnt_q;
        err_d = err_q;
        inc   = 1'b0;
        dec   = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            inc = gnt_c[i] && (xbar_ch_opcode_i[2*i +: 2] == OP_READ);
            dec = bank_rtn_valid_i && (bank_rtn_ch_id_i == CH_W'(i));
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec && !inc) begin
                if (cnt_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        credit_full_o = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            credit_full_o[i] = (cnt_q[i] == CNT_W'(MAX_RD));
        end
    end

    assign bank_valid_o      = bank_valid_q;
    assign bank_ch_id_o      = ch_id_q;
    assign bank_opcode_o     = req_q.opcode;
    assign bank_addr_o       = req_q.addr;
    assign bank_data_o       = req_q.data;
    assign bank_wbuffer_id_o = req_q.wbuffer_id;
    assign err_o             = err_q;

`ifdef XBAR_BANK_ARB_PERF_EN
    logic [NUM_CH-1:0][15:0] perf_gnt_q;
    logic [15:0]             perf_stall_q;

    // Saturating grant and back-pressure counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_gnt_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (gnt_c[i] && (perf_gnt_q[i] != 16'hFFFF)) begin
                    perf_gnt_q[i] <= perf_gnt_q[i] + 16'd1;
                end
            end
            if (bank_valid_q && !bank_allowIn_i && (perf_stall_q != 16'hFFFF)) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end
        end
    end

    assign perf_grant_cnt_o = perf_gnt_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule : xbar_bank_arbiter

// File: tb/tb_xbar_bank_arbiter.sv
// Directed bench for xbar_bank_arbiter: round-robin order, read credits,
// back-pressure, same-cycle credit update, underflow error, async reset.
module tb_xbar_bank_arbiter;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned MAX_RD = 4;
    localparam int unsigned CH_W   = 2;

    logic                clk;
    logic                rst;
    logic [NUM_CH-1:0]   valid;
    logic [NUM_CH-1:0]   ready;
    logic [2*NUM_CH-1:0] op;
    logic [28*NUM_CH-1:0]  addr;
    logic [128*NUM_CH-1:0] data;
    logic [8*NUM_CH-1:0]   wbid;
    logic                bank_valid;
    logic                allow_in;
    logic [CH_W-1:0]     bank_id;
    logic [1:0]          bank_op;
    logic [27:0]         bank_addr;
    logic [127:0]        bank_data;
    logic [7:0]          bank_wbid;
    logic                rtn_valid;
    logic [CH_W-1:0]     rtn_id;
    logic [NUM_CH-1:0]   credit_full;
    logic                err;
`ifdef XBAR_BANK_ARB_PERF_EN
    logic [16*NUM_CH-1:0] perf_gnt;
    logic [15:0]          perf_stall;
`endif

    int n_chk;
    int n_fail;

    xbar_bank_arbiter #(
        .NUM_CH (NUM_CH),
        .MAX_RD (MAX_RD),
        .CH_W   (CH_W)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .xbar_ch_valid_i      (valid),
        .xbar_ch_ready_o      (ready),
        .xbar_ch_opcode_i     (op),
        .xbar_ch_addr_i       (addr),
        .xbar_ch_data_i       (data),
        .xbar_ch_wbuffer_id_i (wbid),
        .bank_valid_o         (bank_valid),
        .bank_allowIn_i       (allow_in),
        .bank_ch_id_o         (bank_id),
        .bank_opcode_o        (bank_op),
        .bank_addr_o          (bank_addr),
        .bank_data_o          (bank_data),
        .bank_wbuffer_id_o    (bank_wbid),
        .bank_rtn_valid_i     (rtn_valid),
        .bank_rtn_ch_id_i     (rtn_id),
        .credit_full_o        (credit_full),
        .err_o                (err)
`ifdef XBAR_BANK_ARB_PERF_EN
        ,
        .perf_grant_cnt_o     (perf_gnt),
        .perf_stall_cnt_o     (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [1:0] o, input logic [27:0] a);
        op[2*ch +: 2]     = o;
        addr[28*ch +: 28] = a;
        data[128*ch +: 128] = {100'h0, a};
        wbid[8*ch +: 8]   = 8'(ch + 8'h10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_CH-1:0] exp_oh;
        n_chk = 0;
        n_fail = 0;
        rst = 1'b0;
        valid = '0;
        op = '0;
        addr = '0;
        data = '0;
        wbid = '0;
        allow_in = 1'b1;
        rtn_valid = 1'b0;
        rtn_id = '0;
        tick();
        tick();
        check("rst_valid", 128'(bank_valid), 128'(0));
        check("rst_ready", 128'(ready), 128'(0));
        check("rst_full", 128'(credit_full), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_addr", 128'(bank_addr), 128'(0));
        rst = 1'b1;

        // All channels WRITE continuously: grants rotate 0,1,2,3,...
        for (int i = 0; i < 4; i++) set_ch(i, 2'b01, 28'h100 + 28'(i));
        valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp_oh = 4'b0001 << (k % 4);
            #1;
            check("rr_ready", 128'(ready), 128'(exp_oh));
            tick();
            check("rr_id", 128'(bank_id), 128'(k % 4));
            check("rr_addr", 128'(bank_addr), 128'(28'h100 + 28'(k % 4)));
            check("rr_valid", 128'(bank_valid), 128'(1));
            if (k == 1) begin
                check("rr_data", bank_data, 128'(28'h101));
                check("rr_wbid", 128'(bank_wbid), 128'(8'h11));
                check("rr_op", 128'(bank_op), 128'(2'b01));
            end
        end
        valid = '0;
        tick();
        check("rr_idle", 128'(bank_valid), 128'(0));

        // Ch1 READs: four accepted, fifth blocked until a return.
        set_ch(1, 2'b00, 28'h200);
        valid = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("cr_ready", 128'(ready), 128'(4'b0010));
            tick();
        end
        check("cr_full", 128'(credit_full), 128'(4'b0010));
        check("cr_op", 128'(bank_op), 128'(2'b00));
        check("cr_id", 128'(bank_id), 128'(1));
        #1;
        check("cr_blocked", 128'(ready), 128'(0));
        tick();
        rtn_valid = 1'b1;
        rtn_id = 2'd1;
        #1;
        check("cr_blocked_rtn", 128'(ready), 128'(0));
        tick();
        rtn_valid = 1'b0;
        check("cr_full_rel", 128'(credit_full), 128'(0));
        #1;
        check("cr_fifth", 128'(ready), 128'(4'b0010));
        tick();
        check("cr_full_again", 128'(credit_full), 128'(4'b0010));
        valid = '0;
        rtn_valid = 1'b1;
        rtn_id = 2'd1;
        repeat (4) tick();
        rtn_valid = 1'b0;
        check("cr_drained", 128'(credit_full), 128'(0));
        check("cr_err", 128'(err), 128'(0));

        // Back-pressure: payload holds, no accepts, completes on allowIn.
        set_ch(0, 2'b01, 28'h0ABCDEF);
        valid = 4'b0001;
        #1;
        check("st_ready0", 128'(ready), 128'(4'b0001));
        tick();
        check("st_valid0", 128'(bank_valid), 128'(1));
        check("st_addr0", 128'(bank_addr), 128'(28'h0ABCDEF));
        allow_in = 1'b0;
        set_ch(0, 2'b01, 28'h1234567);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("st_ready_hold", 128'(ready), 128'(0));
            tick();
            check("st_valid_hold", 128'(bank_valid), 128'(1));
            check("st_addr_hold", 128'(bank_addr), 128'(28'h0ABCDEF));
        end
        allow_in = 1'b1;
        #1;
        check("st_ready_rel", 128'(ready), 128'(4'b0001));
        tick();
        check("st_addr_next", 128'(bank_addr), 128'(28'h1234567));
        valid = '0;
        tick();
        check("st_idle", 128'(bank_valid), 128'(0));

        // Ch2: grant and return in the same cycle with cnt=2 leaves cnt=2.
        set_ch(2, 2'b00, 28'h300);
        valid = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("cd_ready", 128'(ready), 128'(4'b0100));
            tick();
        end
        rtn_valid = 1'b1;
        rtn_id = 2'd2;
        #1;
        check("cd_ready_rtn", 128'(ready), 128'(4'b0100));
        tick();
        rtn_valid = 1'b0;
        check("cd_full2", 128'(credit_full), 128'(0));
        #1;
        check("cd_ready3", 128'(ready), 128'(4'b0100));
        tick();
        check("cd_full3", 128'(credit_full), 128'(0));
        #1;
        check("cd_ready4", 128'(ready), 128'(4'b0100));
        tick();
        check("cd_full4", 128'(credit_full), 128'(4'b0100));
        #1;
        check("cd_blocked", 128'(ready), 128'(0));
        valid = '0;
        check("cd_err_pre", 128'(err), 128'(0));
        rtn_valid = 1'b1;
        rtn_id = 2'd2;
        repeat (4) tick();
        check("cd_drained", 128'(credit_full), 128'(0));
        check("cd_err_drained", 128'(err), 128'(0));
        tick();
        rtn_valid = 1'b0;
        check("cd_err_set", 128'(err), 128'(1));
        tick();
        tick();
        check("cd_err_sticky", 128'(err), 128'(1));

        // Async reset with a staged request and cnt[0]=3.
        set_ch(0, 2'b00, 28'h400);
        valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("rs_ready", 128'(ready), 128'(4'b0001));
            tick();
        end
        check("rs_staged", 128'(bank_valid), 128'(1));
        valid = '0;
        rst = 1'b0;
        #1;
        check("rs_valid", 128'(bank_valid), 128'(0));
        check("rs_addr", 128'(bank_addr), 128'(0));
        check("rs_err", 128'(err), 128'(0));
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) set_ch(i, 2'b00, 28'h500 + 28'(i));
        valid = 4'b1111;
        #1;
        check("rs_first", 128'(ready), 128'(4'b0001));
        tick();
        check("rs_first_id", 128'(bank_id), 128'(0));
        valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("rs_cnt_ready", 128'(ready), 128'(4'b0001));
            tick();
        end
        check("rs_cnt_full", 128'(credit_full), 128'(4'b0001));
        valid = '0;
        tick();

`ifdef XBAR_BANK_ARB_PERF_EN
        // Perf: 10 grants to ch3, then 4 stall cycles.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set_ch(3, 2'b01, 28'h600);
        valid = 4'b1000;
        repeat (10) tick();
        valid = '0;
        allow_in = 1'b0;
        repeat (4) tick();
        allow_in = 1'b1;
        tick();
        check("pf_grant3", 128'(perf_gnt[63:48]), 128'(10));
        check("pf_grant0", 128'(perf_gnt[15:0]), 128'(0));
        check("pf_stall", 128'(perf_stall), 128'(4));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_xbar_bank_arbiter
